// File: rtl/mpram_sclk_lvt_if.sv
// Port bundle for the LVT multi-port RAM: write ports, read ports, busy flag.
interface mpram_sclk_lvt_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NWR        = 2,
  parameter int NRD        = 2
);
  logic [NWR-1:0]            we;
  logic [NWR*ADDR_WIDTH-1:0] waddr;
  logic [NWR*DATA_WIDTH-1:0] wdata;
  logic [NRD-1:0]            re;
  logic [NRD*ADDR_WIDTH-1:0] raddr;
  logic [NRD*DATA_WIDTH-1:0] rdata;
  logic                      busy;

  modport master (
    output we, waddr, wdata, re, raddr,
    input  rdata, busy
  );

  modport slave (
    input  we, waddr, wdata, re, raddr,
    output rdata, busy
  );
endinterface

// File: rtl/mpram_sclk_lvt.sv
// Multi-port RAM (NWR write / NRD read) built from 1W1R banks; a live-value
// table remembers which write port last wrote each address so every read
// port can pick the bank holding the current word. Registered reads with
// enable-hold, optional write-to-read bypass, and a post-reset clear sweep.
module mpram_sclk_lvt #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NWR           = 2,
  parameter int NRD           = 2,
  parameter int CLEAR_ON_INIT = 1,
  parameter int ENABLE_BYPASS = 1
) (
  input  logic           clk,
  input  logic           rst,
  mpram_sclk_lvt_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LVT_W = (NWR > 1) ? $clog2(NWR) : 1;
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                    busy;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [NWR-1:0]          wr_en;

  logic [ADDR_WIDTH-1:0]   wa [NWR];
  logic [DATA_WIDTH-1:0]   wd [NWR];
  logic [ADDR_WIDTH-1:0]   ra [NRD];
  logic [LVT_W-1:0]        lsel [NRD];

  // Banks: one per (write port, read port); data storage, never reset.
  logic [DATA_WIDTH-1:0]   mem [NWR][NRD][DEPTH];
  logic [DEPTH*LVT_W-1:0]  lvt_q;

  logic [DATA_WIDTH-1:0]   rdata_p0 [NRD];
  logic [NRD*DATA_WIDTH-1:0] rdata_p1;

  assign busy     = (state_q == S_CLEAR);
  assign clr_addr = cnt_q[ADDR_WIDTH-1:0];
  assign wr_en    = bus.we & {NWR{~busy}};

  for (genvar w = 0; w < NWR; w++) begin : g_wr
    assign wa[w] = bus.waddr[w*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd[w] = bus.wdata[w*DATA_WIDTH +: DATA_WIDTH];
  end

  // Clear sequencer state: restart the sweep at address 0 on every reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= (CLEAR_ON_INIT != 0) ? S_CLEAR : S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear sequencer next state: one address per cycle, stop after the last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_IDLE;
      end
      default: ;
    endcase
  end

  // Bank writes: port w fills its whole row; the sweep zeroes row 0 only,
  // which is enough because the LVT is forced to point at row 0 as well.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) begin
        for (int r = 0; r < NRD; r++) mem[w][r][wa[w]] <= wd[w];
      end
    end
    if (busy) begin
      for (int r = 0; r < NRD; r++) mem[0][r][clr_addr] <= '0;
    end
  end

  // Live-value table: later loop iterations override, so the highest port wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvt_q <= '0;
    end else if (busy) begin
      lvt_q[clr_addr*LVT_W +: LVT_W] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.we[w]) lvt_q[wa[w]*LVT_W +: LVT_W] <= LVT_W'(w);
      end
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    assign ra[r]   = bus.raddr[r*ADDR_WIDTH +: ADDR_WIDTH];
    assign lsel[r] = lvt_q[ra[r]*LVT_W +: LVT_W];

    // Read select: live bank for this column, overridden by a same-cycle write.
    always_comb begin
      rdata_p0[r] = mem[lsel[r]][r][ra[r]];
      if (ENABLE_BYPASS != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (bus.we[w] && (wa[w] == ra[r])) rdata_p0[r] = wd[w];
        end
      end
    end
  end

  // ---- stage p0 -> p1: registered read data, held while re is low or busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_p1 <= '0;
    end else if (!busy) begin
      for (int r = 0; r < NRD; r++) begin
        if (bus.re[r]) rdata_p1[r*DATA_WIDTH +: DATA_WIDTH] <= rdata_p0[r];
      end
    end
  end

  assign bus.rdata = rdata_p1;
  assign bus.busy  = busy;
endmodule

// File: tb/tb_mpram_sclk_lvt.sv
// Bench for mpram_sclk_lvt: a bypassing and a non-bypassing instance share
// one stimulus stream and are compared every cycle against a flat-array
// memory model, with literal expectations for the directed scenarios.
module tb_mpram_sclk_lvt;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NWR   = 2;
  localparam int NRD   = 2;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst;

  mpram_sclk_lvt_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NWR(NWR), .NRD(NRD)) ifb ();
  mpram_sclk_lvt_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NWR(NWR), .NRD(NRD)) ifn ();

  assign ifn.we    = ifb.we;
  assign ifn.waddr = ifb.waddr;
  assign ifn.wdata = ifb.wdata;
  assign ifn.re    = ifb.re;
  assign ifn.raddr = ifb.raddr;

  mpram_sclk_lvt #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NWR(NWR), .NRD(NRD),
                   .CLEAR_ON_INIT(1), .ENABLE_BYPASS(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  mpram_sclk_lvt #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NWR(NWR), .NRD(NRD),
                   .CLEAR_ON_INIT(1), .ENABLE_BYPASS(0))
    dut_n (.clk(clk), .rst(rst), .bus(ifn));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: one flat memory, writes applied in port order so the
  // highest port lands last; bypass value = memory after this cycle's writes.
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_b [NRD];
  logic [DW-1:0] exp_n [NRD];
  int            clear_left = 0;
  bit            seen_rst   = 1'b0;
  logic [AW-1:0] m_ra;
  logic [DW-1:0] m_old, m_new;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        seen_rst   = 1'b1;
        clear_left = DEPTH;
        for (int r = 0; r < NRD; r++) begin
          exp_b[r] = '0;
          exp_n[r] = '0;
        end
      end else if (clear_left > 0) begin
        clear_left--;
        if (clear_left == 0) begin
          for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
        end
      end else begin
        for (int r = 0; r < NRD; r++) begin
          if (ifb.re[r]) begin
            m_ra  = ifb.raddr[r*AW +: AW];
            m_old = mem_m[m_ra];
            m_new = m_old;
            for (int w = 0; w < NWR; w++) begin
              if (ifb.we[w] && ifb.waddr[w*AW +: AW] == m_ra) m_new = ifb.wdata[w*DW +: DW];
            end
            exp_b[r] = m_new;
            exp_n[r] = m_old;
          end
        end
        for (int w = 0; w < NWR; w++) begin
          if (ifb.we[w]) mem_m[ifb.waddr[w*AW +: AW]] = ifb.wdata[w*DW +: DW];
        end
      end
      #1;
      if (seen_rst) begin
        chk("busy_byp", DW'(ifb.busy), DW'(clear_left > 0));
        chk("busy_nobyp", DW'(ifn.busy), DW'(clear_left > 0));
        for (int r = 0; r < NRD; r++) begin
          chk($sformatf("rdata_byp[%0d]", r), ifb.rdata[r*DW +: DW], exp_b[r]);
          chk($sformatf("rdata_nobyp[%0d]", r), ifn.rdata[r*DW +: DW], exp_n[r]);
        end
      end
    end
  end

  task automatic drive(input logic [1:0] we, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                       input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                       input logic [1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    ifb.we    = we;
    ifb.waddr = {wa1, wa0};
    ifb.wdata = {wd1, wd0};
    ifb.re    = re;
    ifb.raddr = {ra1, ra0};
    @(negedge clk);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) drive(2'b00, '0, '0, '0, '0, 2'b11, AW'(a), AW'(DEPTH - 1 - a));
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (ifb.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, DW'(n), 32'd32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  initial begin
    ifb.we = '0; ifb.waddr = '0; ifb.wdata = '0; ifb.re = '0; ifb.raddr = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", DW'(ifb.busy), 32'd1);
    chk("reset_rdata0", ifb.rdata[31:0], 32'h0);
    chk("reset_rdata1", ifb.rdata[63:32], 32'h0);

    // Clear with every enable held high: nothing may be accepted.
    ifb.we = 2'b11; ifb.waddr = {5'd7, 5'd3}; ifb.wdata = {32'hDEADBEEF, 32'hFEEDF00D};
    ifb.re = 2'b11; ifb.raddr = {5'd7, 5'd3};
    rst = 1'b1;
    count_busy("clear_cycles");
    read_all();
    chk("clear_read_p0", ifb.rdata[31:0], 32'h0);
    chk("clear_read_p1", ifb.rdata[63:32], 32'h0);

    // Independent writes.
    drive(2'b11, 5'd3, 32'hAAAA0001, 5'd7, 32'h55550002, 2'b00, '0, '0);
    drive(2'b00, '0, '0, '0, '0, 2'b11, 5'd3, 5'd7);
    chk("indep_p0", ifb.rdata[31:0], 32'hAAAA0001);
    chk("indep_p1", ifb.rdata[63:32], 32'h55550002);

    // Collision: highest port wins, then a lone port0 write takes over.
    drive(2'b11, 5'd5, 32'h11111111, 5'd5, 32'h22222222, 2'b00, '0, '0);
    drive(2'b00, '0, '0, '0, '0, 2'b11, 5'd5, 5'd5);
    chk("coll_p0", ifb.rdata[31:0], 32'h22222222);
    chk("coll_p1", ifn.rdata[63:32], 32'h22222222);
    drive(2'b01, 5'd5, 32'h33333333, '0, '0, 2'b00, '0, '0);
    drive(2'b00, '0, '0, '0, '0, 2'b11, 5'd5, 5'd5);
    chk("coll2_p0", ifn.rdata[31:0], 32'h33333333);
    chk("coll2_p1", ifb.rdata[63:32], 32'h33333333);

    // Bypass versus old-data read.
    drive(2'b01, 5'd9, 32'h0BAD0000, '0, '0, 2'b00, '0, '0);
    drive(2'b10, '0, '0, 5'd9, 32'hC0DE0009, 2'b01, 5'd9, '0);
    chk("bypass_on", ifb.rdata[31:0], 32'hC0DE0009);
    chk("bypass_off", ifn.rdata[31:0], 32'h0BAD0000);

    // Read hold.
    drive(2'b00, '0, '0, '0, '0, 2'b01, 5'd3, '0);
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, '0, '0, '0, '0, 2'b00, 5'd7, 5'd7);
      chk("hold_p0", ifb.rdata[31:0], 32'hAAAA0001);
    end

    // Random traffic on a narrow address range to force collisions and bypass.
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom), AW'($urandom_range(0, 7)), $urandom, AW'($urandom_range(0, 7)), $urandom,
            2'($urandom), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    // Async reset between edges must clear rdata without a clock.
    drive(2'b01, 5'd1, 32'hFFFF0000, '0, '0, 2'b00, '0, '0);
    drive(2'b00, '0, '0, '0, '0, 2'b01, 5'd1, '0);
    chk("pre_rst_rdata", ifb.rdata[31:0], 32'hFFFF0000);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_rdata", ifb.rdata[31:0], 32'h0);
    chk("async_rst_busy", DW'(ifn.busy), 32'd1);
    repeat (2) @(negedge clk);

    // Mid-clear reset: restart and run a full sweep again.
    ifb.we = 2'b11; ifb.re = 2'b11;
    rst = 1'b1;
    repeat (17) @(negedge clk);
    chk("midclear_busy", DW'(ifb.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("midclear_rdata", ifb.rdata[31:0], 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    count_busy("reclear_cycles");
    read_all();
    chk("reclear_read_p0", ifb.rdata[31:0], 32'h0);
    chk("reclear_read_p1", ifn.rdata[63:32], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
